wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter that owns the single register-file write port (`we`/`waddr`/`wdata`). It merges two result sources: the in-order pipeline writeback, which is never back-pressured, and a long-latency unit (mul/div, uncached loads) whose results arrive out of band through a valid/ready handshake and a small FIFO. It also keeps a 32-bit pending scoreboard so decode can hold instructions whose source register still awaits a long-latency result.

## Interface
Parameters:
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width; scoreboard has 2^ADDR_W bits
- `FIFO_DEPTH`, 2, long-latency result buffer entries (power of two, ≥2)
- `STARVE_MAX`, 4, consecutive blocked cycles before the pipeline is stalled

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset (0 = reset)
- `pipe_we` in 1: pipeline writeback valid
- `pipe_waddr` in ADDR_W: pipeline destination
- `pipe_wdata` in DATA_W: pipeline result
- `pipe_stall` out 1: pipeline must hold its writeback inputs this cycle
- `lu_valid` in 1: long-latency result valid
- `lu_ready` out 1: FIFO can accept
- `lu_waddr` in ADDR_W: long-latency destination
- `lu_wdata` in DATA_W: long-latency result
- `issue_valid` in 1: a long-latency op issued this cycle
- `issue_waddr` in ADDR_W: its destination
- `pending` out 2^ADDR_W: bit n = register n awaits a long-latency result
- `we` out 1: regfile write enable (registered)
- `waddr` out ADDR_W: regfile write address (registered)
- `wdata` out DATA_W: regfile write data (registered)

## Operation
- Output stage: `we`/`waddr`/`wdata` are flops loaded every cycle from the selected source. If no source is selected, `we` = 0 and `waddr`/`wdata` hold their previous values.
- Selection in each cycle, in priority order:
  1. If `pipe_stall` = 1 and the FIFO is non-empty: pop the FIFO head.
  2. Else if `pipe_we` = 1: take the pipeline write.
  3. Else if the FIFO is non-empty: pop the FIFO head.
  4. Else: idle.
- While `pipe_stall` = 1, pipeline inputs are ignored. Upstream holds them, so nothing is lost.
- Writes to address 0:
  - A pipeline write with `pipe_waddr` = 0 still counts as selected and produces `we` = 1.
  - A FIFO entry with address 0 is popped but produces `we` = 0.
- FIFO:
  - `lu_ready` = not full (0 while in reset).
  - Push on `lu_valid & lu_ready`. Push and pop in the same cycle are legal when full; `lu_ready` stays 0 in that cycle.
  - Pointers wrap modulo `FIFO_DEPTH`. Occupancy counter is log2(`FIFO_DEPTH`)+1 bits.
  - FIFO order is preserved.
- Starvation counter (`starve_cnt`):
  - Increments each cycle the FIFO is non-empty and the pipeline wins selection.
  - Clears on any FIFO pop or when the FIFO is empty.
  - `pipe_stall` is registered: it is 1 in the cycle after `starve_cnt` reaches `STARVE_MAX`.
  - `pipe_stall` falls in the cycle after the FIFO becomes empty.
- Scoreboard:
  - Set bit `issue_waddr` on `issue_valid` when `issue_waddr` ≠ 0.
  - Clear bit `lu_waddr` of the popped head at the edge that loads it into the output stage.
  - Set and clear of the same bit in the same cycle: set wins.
  - Bit 0 is always 0. Pipeline writes never affect `pending`.

## Timing
- Reset (async, `rst` = 0): `we` = 0, `waddr` = 0, `wdata` = 0, `pending` = 0, `pipe_stall` = 0, `lu_ready` = 0, FIFO empty, `starve_cnt` = 0. All state returns to these values immediately, including mid-handshake; buffered results are discarded.
- Pipeline latency: `pipe_we` sampled at edge t drives `we` = 1 in cycle t+1.
- Long-latency latency: push at edge t; earliest pop is selected in cycle t+1; `we` = 1 in cycle t+2. There is no bypass around an empty FIFO.
- The `pending` bit falls in the same cycle the corresponding `we` = 1 is visible, so decode can use the regfile's write-through read path.
- Sustained throughput: one regfile write per cycle.

## Test plan
- Reset then `pipe_we`=1, `pipe_waddr`=3, `pipe_wdata`=0x1234 → next cycle `we`=1, `waddr`=3, `wdata`=0x1234. `pending`=0 throughout.
- `issue_valid`, `issue_waddr`=7; later `lu_valid`, `lu_waddr`=7, `lu_wdata`=0xDEAD with the pipeline idle → `pending[7]`=1 until the cycle `we`=1, `waddr`=7, `wdata`=0xDEAD, i.e. 2 cycles after the push.
- Push 2 LU results with `pipe_we` held high → `lu_ready`=0 after the second push. `pipe_stall` rises after `STARVE_MAX`=4 blocked cycles. Both results are written in order. `pipe_stall` drops, then the held pipeline write is written.
- Same cycle: pop of reg 5 and `issue_valid` to reg 5 → `pending[5]` stays 1. LU result with `lu_waddr`=0 → popped, `we`=0.
- Full FIFO with simultaneous push and pop → no data lost; `lu_ready`=0 that cycle; order preserved.
- Assert `rst`=0 asynchronously mid-stream with the FIFO full → all outputs at reset values before the next edge. After release, `lu_ready`=1 and no stale write appears.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline writeback, long-latency result handshake,
// issue tracking, scoreboard and the registered regfile write port.
interface wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                   pipe_we;
    logic [ADDR_W-1:0]      pipe_waddr;
    logic [DATA_W-1:0]      pipe_wdata;
    logic                   pipe_stall;

    logic                   lu_valid;
    logic                   lu_ready;
    logic [ADDR_W-1:0]      lu_waddr;
    logic [DATA_W-1:0]      lu_wdata;

    logic                   issue_valid;
    logic [ADDR_W-1:0]      issue_waddr;
    logic [(2**ADDR_W)-1:0] pending;

    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;

    // Arbiter side.
    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  lu_valid, lu_waddr, lu_wdata,
        input  issue_valid, issue_waddr,
        output pipe_stall, lu_ready, pending,
        output we, waddr, wdata
    );

    // Pipeline / long-latency unit / regfile side.
    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output lu_valid, lu_waddr, lu_wdata,
        output issue_valid, issue_waddr,
        input  pipe_stall, lu_ready, pending,
        input  we, waddr, wdata
    );
endinterface

// File: rtl/wb_arbiter.sv
// Owns the single regfile write port. Merges the never-back-pressured pipeline
// writeback with buffered long-latency results, stalls the pipeline when the
// buffer has been starved too long, and tracks registers awaiting results.
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam int NREG  = 2 ** ADDR_W;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              stall_q, stall_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NREG-1:0]   pending_q, pending_d;

    logic              fifo_ne, fifo_full, take_pipe, pop, push;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign fifo_ne   = (count_q != '0);
    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign head_addr = fifo_addr_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    // While stalled the pipeline inputs are ignored; upstream holds them.
    assign take_pipe = ~stall_q & bus.pipe_we;
    // Any non-empty cycle the pipeline does not win is a pop.
    assign pop       = fifo_ne & ~take_pipe;
    assign push      = bus.lu_valid & bus.lu_ready;

    assign bus.lu_ready   = rst & ~fifo_full;
    assign bus.pipe_stall = stall_q;
    assign bus.pending    = pending_q;
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;

    // Next-state: source selection, FIFO bookkeeping, starvation and scoreboard.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        pending_d = pending_q;
        starve_d  = '0;
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

        if (take_pipe) begin
            we_d    = 1'b1;
            waddr_d = bus.pipe_waddr;
            wdata_d = bus.pipe_wdata;
        end else if (pop) begin
            // Results for r0 drain from the buffer but never reach the regfile.
            we_d    = (head_addr != '0);
            waddr_d = head_addr;
            wdata_d = head_data;
            pending_d[head_addr] = 1'b0;
        end

        // Applied after the clear so a same-cycle set wins.
        if (bus.issue_valid && bus.issue_waddr != '0) begin
            pending_d[bus.issue_waddr] = 1'b1;
        end
        pending_d[0] = 1'b0;

        if (take_pipe && fifo_ne) begin
            starve_d = starve_q + STV_W'(1);
        end

        // Stall once the buffer has lost STARVE_MAX times in a row; release as
        // soon as the buffer drains so no bubble is inserted.
        stall_d = (starve_d == STV_W'(STARVE_MAX)) | (stall_q & (count_d != '0));
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
        end
    end

    // FIFO storage, written on push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the occupancy counter alone marks entries valid.
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.lu_waddr;
            fifo_data_q[wr_ptr_q] <= bus.lu_wdata;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-based behavioural model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_arbiter;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 4;
    localparam int NREG       = 2 ** ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    wb_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              mq[$];
    logic              m_we    = 1'b0;
    logic [ADDR_W-1:0] m_waddr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [NREG-1:0]   m_pend  = '0;
    logic              m_stall = 1'b0;
    int                m_wins  = 0;

    task automatic model_reset();
        mq.delete();
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_pend  = '0;
        m_stall = 1'b0;
        m_wins  = 0;
    endtask

    task automatic model_step();
        bit   ne, take, pop, push;
        ent_t h;
        ne   = (mq.size() != 0);
        take = !m_stall && bus.pipe_we;
        pop  = ne && !take;
        push = bus.lu_valid && (mq.size() < FIFO_DEPTH);
        if (take) begin
            m_we    = 1'b1;
            m_waddr = bus.pipe_waddr;
            m_wdata = bus.pipe_wdata;
        end else if (pop) begin
            h = mq.pop_front();
            m_we = (h.a != 0);
            if (h.a != 0) begin
                m_waddr = h.a;
                m_wdata = h.d;
            end
            m_pend[h.a] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (bus.issue_valid && bus.issue_waddr != 0) m_pend[bus.issue_waddr] = 1'b1;
        if (push) mq.push_back('{a: bus.lu_waddr, d: bus.lu_wdata});
        // Consecutive pipeline wins while something waited in the buffer.
        m_wins = (ne && take) ? m_wins + 1 : 0;
        if (m_wins >= STARVE_MAX) m_stall = 1'b1;
        else if (mq.size() == 0) m_stall = 1'b0;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) model_reset();
        else      model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("m_we", bus.we, m_we);
            if (m_we) begin
                check("m_waddr", bus.waddr, m_waddr);
                check("m_wdata", bus.wdata, m_wdata);
            end
            check("m_pending", bus.pending, m_pend);
            check("m_stall", bus.pipe_stall, m_stall);
            check("m_ready", bus.lu_ready, (rst && mq.size() < FIFO_DEPTH));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bus.pipe_we     = 1'b0;
        bus.pipe_waddr  = '0;
        bus.pipe_wdata  = '0;
        bus.lu_valid    = 1'b0;
        bus.lu_waddr    = '0;
        bus.lu_wdata    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_waddr = '0;

        repeat (3) @(negedge clk);
        check("rst_we", bus.we, 0);
        check("rst_waddr", bus.waddr, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_stall", bus.pipe_stall, 0);
        check("rst_ready", bus.lu_ready, 0);
        @(posedge clk); #2 rst = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        check("ready_after_rst", bus.lu_ready, 1);

        // Pipeline write appears one cycle later.
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd3; bus.pipe_wdata = 32'h1234;
        @(negedge clk);
        bus.pipe_we = 1'b0;
        check("t1_we", bus.we, 1);
        check("t1_waddr", bus.waddr, 3);
        check("t1_wdata", bus.wdata, 32'h1234);
        check("t1_pending", bus.pending, 0);
        @(negedge clk);
        check("t1_idle_we", bus.we, 0);

        // Long-latency result: pending until the write is visible, 2 cycles after push.
        bus.issue_valid = 1'b1; bus.issue_waddr = 5'd7;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        check("t2_pend_set", bus.pending[7], 1);
        @(negedge clk);
        bus.lu_valid = 1'b1; bus.lu_waddr = 5'd7; bus.lu_wdata = 32'hDEAD;
        @(negedge clk);
        bus.lu_valid = 1'b0;
        check("t2_no_bypass_we", bus.we, 0);
        check("t2_pend_held", bus.pending[7], 1);
        @(negedge clk);
        check("t2_we", bus.we, 1);
        check("t2_waddr", bus.waddr, 7);
        check("t2_wdata", bus.wdata, 32'hDEAD);
        check("t2_pend_clr", bus.pending[7], 0);

        // Starvation: two buffered results behind a continuous pipeline stream.
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd9; bus.pipe_wdata = 32'h99;
        bus.lu_valid = 1'b1; bus.lu_waddr = 5'd10; bus.lu_wdata = 32'hA0;
        @(negedge clk);
        bus.lu_waddr = 5'd11; bus.lu_wdata = 32'hB1;
        @(negedge clk);
        bus.lu_valid = 1'b0;
        check("t3_full_ready", bus.lu_ready, 0);
        check("t3_pipe_wins", bus.waddr, 9);
        @(negedge clk);
        @(negedge clk);
        check("t3_stall_not_yet", bus.pipe_stall, 0);
        @(negedge clk);
        check("t3_stall_rise", bus.pipe_stall, 1);
        @(negedge clk);
        check("t3_first_waddr", bus.waddr, 10);
        check("t3_first_wdata", bus.wdata, 32'hA0);
        @(negedge clk);
        check("t3_second_waddr", bus.waddr, 11);
        check("t3_second_wdata", bus.wdata, 32'hB1);
        check("t3_stall_fall", bus.pipe_stall, 0);
        @(negedge clk);
        bus.pipe_we = 1'b0;
        check("t3_held_we", bus.we, 1);
        check("t3_held_waddr", bus.waddr, 9);
        check("t3_held_wdata", bus.wdata, 32'h99);
        @(negedge clk);
        check("t3_idle_we", bus.we, 0);

        // Same-cycle clear and set of r5; then a result for r0.
        bus.issue_valid = 1'b1; bus.issue_waddr = 5'd5;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.lu_valid = 1'b1; bus.lu_waddr = 5'd5; bus.lu_wdata = 32'h55;
        @(negedge clk);
        bus.lu_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_waddr = 5'd5;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        check("t4_we", bus.we, 1);
        check("t4_waddr", bus.waddr, 5);
        check("t4_set_wins", bus.pending[5], 1);
        bus.lu_valid = 1'b1; bus.lu_waddr = 5'd0; bus.lu_wdata = 32'hBAD;
        @(negedge clk);
        bus.lu_valid = 1'b0;
        @(negedge clk);
        check("t4_r0_we", bus.we, 0);
        check("t4_r0_ready", bus.lu_ready, 1);

        // Full buffer with a pending third result; order must be preserved.
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd2; bus.pipe_wdata = 32'h22;
        bus.lu_valid = 1'b1; bus.lu_waddr = 5'd12; bus.lu_wdata = 32'hC0;
        @(negedge clk);
        bus.lu_waddr = 5'd13; bus.lu_wdata = 32'hD0;
        @(negedge clk);
        bus.lu_waddr = 5'd14; bus.lu_wdata = 32'hE0;
        bus.pipe_we = 1'b0;
        check("t5_full_ready", bus.lu_ready, 0);
        @(negedge clk);
        check("t5_a_waddr", bus.waddr, 12);
        check("t5_a_wdata", bus.wdata, 32'hC0);
        check("t5_ready_again", bus.lu_ready, 1);
        @(negedge clk);
        bus.lu_valid = 1'b0;
        check("t5_b_waddr", bus.waddr, 13);
        @(negedge clk);
        check("t5_c_waddr", bus.waddr, 14);
        check("t5_c_wdata", bus.wdata, 32'hE0);

        // Asynchronous reset mid-stream with the buffer full.
        bus.issue_valid = 1'b1; bus.issue_waddr = 5'd20;
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd1; bus.pipe_wdata = 32'h11;
        bus.lu_valid = 1'b1; bus.lu_waddr = 5'd21; bus.lu_wdata = 32'h2100;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.lu_waddr = 5'd22; bus.lu_wdata = 32'h2200;
        @(negedge clk);
        bus.lu_valid = 1'b0;
        check("t6_pre_ready", bus.lu_ready, 0);
        check("t6_pre_pend", bus.pending[20], 1);
        check("t6_pre_we", bus.we, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_async_we", bus.we, 0);
        check("t6_async_waddr", bus.waddr, 0);
        check("t6_async_wdata", bus.wdata, 0);
        check("t6_async_pending", bus.pending, 0);
        check("t6_async_stall", bus.pipe_stall, 0);
        check("t6_async_ready", bus.lu_ready, 0);
        bus.pipe_we = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_stale_we", bus.we, 0);
            check("t6_ready", bus.lu_ready, 1);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
